i2c_target_regfile: RTL and testbench

- Synthesizable I2C target (slave) that responds to a single 7-bit address and exposes an internal byte-wide register file.
- It is the far end of the open-drain bus driven by the VIP initiator.
- It samples the resolved scl/sda wires through synchronizers.
- It drives the bus only through active-low release/pull-down controls: '1' = release (high-Z), '0' = drive low. Bench pull-ups resolve the wires.

---
 rtl/i2c_target_regfile.sv | 198 +++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target at one 7-bit address fronting a byte register file (pointer write, auto-increment).
// Optional SCL stretching before each read byte is enabled by defining I2C_TARGET_CLK_STRETCH_EN.
module i2c_target_regfile #(
    parameter logic [6:0]  TARGET_ADDR    = 7'h50,
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned STRETCH_CYCLES = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        scl_drive,
    output logic                        sda_drive,
    input  logic [$clog2(NUM_REGS)-1:0] host_addr,
    output logic [7:0]                  host_rdata,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic                        busy
);
    localparam int unsigned IW = $clog2(NUM_REGS);

    if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0 || STRETCH_CYCLES < 1)
    begin : g_bad_params
        $error("i2c_target_regfile: NUM_REGS must be a power of 2 in 2..256, STRETCH_CYCLES >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    state_t          state;
    logic [2:0]      bit_cnt;
    logic            byte_done;
    logic [7:0]      rx_byte;
    logic [7:0]      tx_byte;
    logic            rw;
    logic            rack_nack;
    logic [IW-1:0]   ptr;
    logic [7:0]      regs [NUM_REGS];

    // Two-flop synchronizers; idle-high reset values avoid false edges out of reset.
    logic [1:0] scl_ff, sda_ff;
    logic       scl_prev, sda_prev;
    logic       scl_sync, sda_sync;
    logic       scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff   <= 2'b11;
            sda_ff   <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_ff   <= {scl_ff[0], scl_in};
            sda_ff   <= {sda_ff[0], sda_in};
            scl_prev <= scl_ff[1];
            sda_prev <= sda_ff[1];
        end
    end

    assign scl_sync  = scl_ff[1];
    assign sda_sync  = sda_ff[1];
    assign scl_rise  = scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync & scl_prev;
    assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

    assign host_rdata = regs[host_addr];

    // Bits are sampled on SCL rise; SDA is only updated on SCL fall so it never moves while SCL is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            rx_byte   <= '0;
            tx_byte   <= '0;
            rw        <= 1'b0;
            rack_nack <= 1'b0;
            ptr       <= '0;
            sda_drive <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state     <= IDLE;
                sda_drive <= 1'b1;
                busy      <= 1'b0;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                sda_drive <= 1'b1;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
            end else if (scl_rise) begin
                if (state inside {ADDR, PTR, WDATA, RDATA}) begin
                    rx_byte <= {rx_byte[6:0], sda_sync};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) byte_done <= 1'b1;
                end
                if (state == RACK) rack_nack <= sda_sync;
            end else if (scl_fall) begin
                case (state)
                    ADDR: if (byte_done) begin
                        byte_done <= 1'b0;
                        if (rx_byte[7:1] == TARGET_ADDR) begin
                            state     <= ADDR_ACK;
                            sda_drive <= 1'b0;
                            busy      <= 1'b1;
                            rw        <= rx_byte[0];
                        end else begin
                            state <= IDLE;
                        end
                    end
                    ADDR_ACK: if (rw) begin
                        state     <= RDATA;
                        sda_drive <= regs[ptr][7];
                        tx_byte   <= {regs[ptr][6:0], 1'b0};
                    end else begin
                        state     <= PTR;
                        sda_drive <= 1'b1;
                    end
                    PTR: if (byte_done) begin
                        byte_done <= 1'b0;
                        ptr       <= rx_byte[IW-1:0];
                        state     <= PTR_ACK;
                        sda_drive <= 1'b0;
                    end
                    PTR_ACK: begin
                        state     <= WDATA;
                        sda_drive <= 1'b1;
                    end
                    WDATA: if (byte_done) begin
                        byte_done <= 1'b0;
                        regs[ptr] <= rx_byte;
                        wr_strobe <= 1'b1;
                        wr_index  <= ptr;
                        ptr       <= ptr + IW'(1);
                        state     <= WDATA_ACK;
                        sda_drive <= 1'b0;
                    end
                    WDATA_ACK: begin
                        state     <= WDATA;
                        sda_drive <= 1'b1;
                    end
                    RDATA: if (byte_done) begin
                        byte_done <= 1'b0;
                        state     <= RACK;
                        sda_drive <= 1'b1;
                    end else begin
                        sda_drive <= tx_byte[7];
                        tx_byte   <= {tx_byte[6:0], 1'b0};
                    end
                    RACK: if (!rack_nack) begin
                        ptr       <= ptr + IW'(1);
                        sda_drive <= regs[ptr + IW'(1)][7];
                        tx_byte   <= {regs[ptr + IW'(1)][6:0], 1'b0};
                        state     <= RDATA;
                    end else begin
                        state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef I2C_TARGET_CLK_STRETCH_EN
    localparam int unsigned SCW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;

    logic [SCW-1:0] stretch_cnt;
    logic           stretch_go;

    // Hold SCL low at the start of each read byte while the first bit settles on SDA.
    assign stretch_go = scl_fall && !start_det && !stop_det &&
                        ((state == ADDR_ACK && rw) || (state == RACK && !rack_nack));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_drive   <= 1'b1;
            stretch_cnt <= '0;
        end else if (stretch_go) begin
            scl_drive   <= 1'b0;
            stretch_cnt <= SCW'(STRETCH_CYCLES - 1);
        end else if (!scl_drive) begin
            if (stretch_cnt == '0) scl_drive <= 1'b1;
            else                   stretch_cnt <= stretch_cnt - SCW'(1);
        end
    end
`else
    assign scl_drive = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged initiator, byte-level register model, per-cycle output checks.
module tb_i2c_target_regfile;
    localparam int         Q     = 6;
    localparam int         NREGS = 16;
    localparam logic [6:0] TADDR = 7'h50;

    logic       clk, rst_n;
    logic       scl_m, sda_m;
    logic       scl_in, sda_in;
    logic       scl_drive, sda_drive;
    logic [3:0] host_addr;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_index;
    logic       busy;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] m_regs [NREGS];
    int         m_ptr;
    int         exp_idx[$];
    logic [7:0] wbuf [4];
    logic [7:0] rbuf [4];
    bit         miss_win;
    bit         prev_scl, prev_drv;
    int         low_run, stretch_seen;

    assign scl_in = scl_m & scl_drive;
    assign sda_in = sda_m & sda_drive;

    i2c_target_regfile #(
        .TARGET_ADDR(TADDR), .NUM_REGS(NREGS), .STRETCH_CYCLES(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
        .scl_drive(scl_drive), .sda_drive(sda_drive), .host_addr(host_addr),
        .host_rdata(host_rdata), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Release SCL and wait for the wire to go high (the target may be stretching).
    task automatic scl_high();
        int k;
        scl_m = 1'b1;
        k = 0;
        while (!scl_in && k < 200) begin
            tick(1);
            k++;
        end
        if (!scl_in) chk("scl_release_timeout", 32'(scl_in), 32'd1);
    endtask

    task automatic send_bit(input logic b);
        tick(Q); sda_m = b; tick(Q);
        scl_high(); tick(2 * Q);
        scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        tick(Q); sda_m = 1'b1; tick(Q);
        scl_high(); tick(Q);
        b = sda_in;
        tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    task automatic start_c();
        if (!scl_m) begin
            tick(Q); sda_m = 1'b1; tick(Q);
            scl_high();
        end
        tick(Q); sda_m = 1'b0; tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic stop_c();
        tick(Q); sda_m = 1'b0; tick(Q);
        scl_high(); tick(Q);
        sda_m = 1'b1;
        tick(2 * Q);
    endtask

    // Write transaction: device address, pointer byte, then n data bytes from wbuf.
    task automatic xfer_write(input logic [6:0] a, input logic [7:0] p, input int n);
        logic ack;
        bit   hit;
        hit = (a == TADDR);
        start_c();
        write_byte({a, 1'b0}, ack);
        chk("wr_addr_ack", 32'(ack), 32'(hit));
        write_byte(p, ack);
        chk("wr_ptr_ack", 32'(ack), 32'(hit));
        if (hit) m_ptr = int'(p) % NREGS;
        for (int i = 0; i < n; i++) begin
            if (hit) exp_idx.push_back(m_ptr);
            write_byte(wbuf[i], ack);
            chk("wr_data_ack", 32'(ack), 32'(hit));
            if (hit) begin
                m_regs[m_ptr] = wbuf[i];
                m_ptr = (m_ptr + 1) % NREGS;
            end
        end
        chk("busy_in_xfer", 32'(busy), 32'(hit));
        stop_c();
        chk("busy_after_stop", 32'(busy), 32'd0);
    endtask

    // Read n bytes, optionally setting the pointer first with a write and repeated start.
    task automatic xfer_read(input logic [7:0] p, input bit set_ptr, input int n);
        logic ack;
        logic [7:0] d;
        start_c();
        if (set_ptr) begin
            write_byte({TADDR, 1'b0}, ack);
            chk("rd_waddr_ack", 32'(ack), 32'd1);
            write_byte(p, ack);
            chk("rd_ptr_ack", 32'(ack), 32'd1);
            m_ptr = int'(p) % NREGS;
            start_c();
        end
        write_byte({TADDR, 1'b1}, ack);
        chk("rd_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, d);
            chk("rd_data", 32'(d), 32'(m_regs[m_ptr]));
            rbuf[i] = d;
            if (i < n - 1) m_ptr = (m_ptr + 1) % NREGS;
        end
        tick(4);
        chk("sda_released_after_nack", 32'(sda_drive), 32'd1);
        chk("busy_after_nack", 32'(busy), 32'd1);
        stop_c();
        chk("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic sweep_regs();
        for (int i = 0; i < NREGS; i++) begin
            host_addr = 4'(i);
            tick(1);
            chk("host_rdata", 32'(host_rdata), 32'(m_regs[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endtask

    // Per-cycle output checks against the model's expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_scl = 1'b1;
            prev_drv = 1'b1;
            low_run  = 0;
        end else begin
            if (wr_strobe) begin
                if (exp_idx.size() == 0) begin
                    checks++;
                    $display("FAIL wr_strobe_unexpected: got strobe at index %0d expected none", wr_index);
                end else begin
                    chk("wr_index", 32'(wr_index), 32'(exp_idx.pop_front()));
                end
            end
            if (scl_in && prev_scl)
                chk("sda_pulled_while_scl_high", 32'(prev_drv & ~sda_drive), 32'd0);
            if (miss_win) chk("miss_sda_released", 32'(sda_drive), 32'd1);
`ifdef I2C_TARGET_CLK_STRETCH_EN
            if (!scl_drive) begin
                low_run++;
            end else if (low_run != 0) begin
                chk("stretch_len", 32'(low_run), 32'd32);
                low_run = 0;
                stretch_seen++;
            end
`else
            chk("scl_never_driven", 32'(scl_drive), 32'd1);
`endif
            prev_scl = scl_in;
            prev_drv = sda_drive;
        end
    end

    initial begin
        logic ack;
        int   kind, n;
        logic [6:0] a;

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; host_addr = '0;
        miss_win = 1'b0; stretch_seen = 0;
        model_reset();
        tick(3);
        chk("rst_sda_drive", 32'(sda_drive), 32'd1);
        chk("rst_scl_drive", 32'(scl_drive), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_wr_index", 32'(wr_index), 32'd0);
        rst_n = 1'b1;
        tick(4);
        sweep_regs();

        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        xfer_write(TADDR, 8'h03, 2);
        host_addr = 4'd3; tick(1);
        chk("burst_reg3", 32'(host_rdata), 32'h5A);
        host_addr = 4'd4; tick(1);
        chk("burst_reg4", 32'(host_rdata), 32'hC3);

        xfer_read(8'h03, 1'b1, 2);
        chk("combined_rd0", 32'(rbuf[0]), 32'h5A);
        chk("combined_rd1", 32'(rbuf[1]), 32'hC3);

        miss_win = 1'b1;
        xfer_write(7'h58, 8'h00, 0);
        miss_win = 1'b0;
        sweep_regs();

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        xfer_write(TADDR, 8'h0F, 2);
        host_addr = 4'd15; tick(1);
        chk("wrap_reg15", 32'(host_rdata), 32'h11);
        host_addr = 4'd0; tick(1);
        chk("wrap_reg0", 32'(host_rdata), 32'h22);

        for (int t = 0; t < 14; t++) begin
            kind = int'($urandom_range(0, 3));
            n    = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            case (kind)
                0: xfer_write(TADDR, 8'($urandom), n);
                1: xfer_read(8'($urandom), 1'b1, n);
                2: xfer_read(8'h00, 1'b0, n);
                default: begin
                    a = 7'($urandom_range(0, 127));
                    if (a == TADDR) a = 7'h51;
                    miss_win = 1'b1;
                    xfer_write(a, 8'($urandom), n);
                    miss_win = 1'b0;
                end
            endcase
        end
        sweep_regs();

        // Reset while the target drives bit 7 (a 0) of 0x5A.
        wbuf[0] = 8'h5A;
        xfer_write(TADDR, 8'h03, 1);
        start_c();
        write_byte({TADDR, 1'b0}, ack);
        write_byte(8'h03, ack);
        start_c();
        write_byte({TADDR, 1'b1}, ack);
        chk("midrd_addr_ack", 32'(ack), 32'd1);
        tick(5);
        chk("midrd_bit7_driven_low", 32'(sda_drive), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrd_rst_sda", 32'(sda_drive), 32'd1);
        chk("midrd_rst_scl", 32'(scl_drive), 32'd1);
        chk("midrd_rst_busy", 32'(busy), 32'd0);
        tick(2);
        scl_m = 1'b1; tick(2); sda_m = 1'b1; tick(2);
        rst_n = 1'b1;
        model_reset();
        tick(4);
        sweep_regs();

        chk("strobes_all_seen", 32'(exp_idx.size()), 32'd0);
`ifdef I2C_TARGET_CLK_STRETCH_EN
        chk("stretch_occurred", 32'(stretch_seen > 0), 32'd1);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
